// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, debounce FSM, and registered
// level / press / release / hold outputs for one physical button.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 0,
    parameter int CNT_WIDTH       = 27,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_hold
);

    localparam logic                 SYNC_IDLE = ACTIVE_LOW;
    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LIM  = CNT_WIDTH'(HOLD_CYCLES);
    localparam bit                   HOLD_EN   = (HOLD_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   dcnt;
    logic [CNT_WIDTH-1:0]   hcnt;
    logic                   s;

    // Raw pin goes straight into flop 0; polarity is fixed up after the chain.
    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            hcnt      <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            btn_hold  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            btn_hold <= 1'b0;

            // Hold timer runs while the committed level is high, release
            // bounce included; it saturates so the pulse fires once per press.
            if (HOLD_EN && btn_level && hcnt != HOLD_LIM) begin
                hcnt <= hcnt + 1'b1;
                if (hcnt == HOLD_LIM - 1'b1)
                    btn_hold <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (s) begin
                        state <= WAIT_PRESS;
                        dcnt  <= CNT_WIDTH'(1);
                    end
                end
                WAIT_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == DB_LAST) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                        dcnt      <= '0;
                        hcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= WAIT_RELEASE;
                        dcnt  <= CNT_WIDTH'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (s) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                    end else if (dcnt == DB_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                        dcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dcnt  <= '0;
                end
            endcase
        end
    end

endmodule
